// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types and sizes for the dual-issue scheduler and its scoreboard.
package spu_sched_pkg;

  localparam int NUM_REGS = 128;
  localparam int REG_W    = 7;
  localparam int LAT_W    = 4;

  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } pipe_t;

  // One decoded instruction slot; use_src bit0/1/2 flag ra/rb/rc as real sources.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] rt;
    logic [2:0]       use_src;
    logic             wr;
    pipe_t            pipe;
    logic [LAT_W-1:0] lat;
  } slot_t;

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Decoder-to-scheduler bundle: pair handshake, both slot descriptors and issue results.
interface dual_issue_scheduler_if;
  import spu_sched_pkg::*;

  logic             flush_i;
  logic             pair_valid_i;
  logic             in_ready_o;
  logic             valid_1;
  logic             valid_2;
  logic [REG_W-1:0] ra_1, rb_1, rc_1, rt_1;
  logic [REG_W-1:0] ra_2, rb_2, rc_2, rt_2;
  logic [2:0]       use_1, use_2;
  logic             wr_1, wr_2;
  logic             pipe_1, pipe_2;
  logic [LAT_W-1:0] lat_1, lat_2;
  logic             issue1_o;
  logic             issue2_o;
  logic             split_o;

  // Decoder side drives the pair and observes the issue decision.
  modport master (
    output flush_i, pair_valid_i,
    output valid_1, ra_1, rb_1, rc_1, rt_1, use_1, wr_1, pipe_1, lat_1,
    output valid_2, ra_2, rb_2, rc_2, rt_2, use_2, wr_2, pipe_2, lat_2,
    input  in_ready_o, issue1_o, issue2_o, split_o
  );

  // Scheduler side.
  modport slave (
    input  flush_i, pair_valid_i,
    input  valid_1, ra_1, rb_1, rc_1, rt_1, use_1, wr_1, pipe_1, lat_1,
    input  valid_2, ra_2, rb_2, rc_2, rt_2, use_2, wr_2, pipe_2, lat_2,
    output in_ready_o, issue1_o, issue2_o, split_o
  );

endinterface

// File: rtl/dual_issue_scheduler_scoreboard.sv
// Per-register result-latency scoreboard: counters count down to zero, issuing
// writers reload their destination, two read groups serve the two slots.
module sched_scoreboard
  import spu_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ld1_en_i,
  input  logic [REG_W-1:0] ld1_addr_i,
  input  logic [LAT_W-1:0] ld1_lat_i,
  input  logic             ld2_en_i,
  input  logic [REG_W-1:0] ld2_addr_i,
  input  logic [LAT_W-1:0] ld2_lat_i,
  input  logic [REG_W-1:0] rd1_ra_i,
  input  logic [REG_W-1:0] rd1_rb_i,
  input  logic [REG_W-1:0] rd1_rc_i,
  input  logic [REG_W-1:0] rd1_rt_i,
  output logic [LAT_W-1:0] rd1_ra_o,
  output logic [LAT_W-1:0] rd1_rb_o,
  output logic [LAT_W-1:0] rd1_rc_o,
  output logic [LAT_W-1:0] rd1_rt_o,
  input  logic [REG_W-1:0] rd2_ra_i,
  input  logic [REG_W-1:0] rd2_rb_i,
  input  logic [REG_W-1:0] rd2_rc_i,
  input  logic [REG_W-1:0] rd2_rt_i,
  output logic [LAT_W-1:0] rd2_ra_o,
  output logic [LAT_W-1:0] rd2_rb_o,
  output logic [LAT_W-1:0] rd2_rc_o,
  output logic [LAT_W-1:0] rd2_rt_o
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  // Next count: decrement toward zero; a load wins over the decrement.
  // The pair logic never loads the same register from both slots in one cycle;
  // slot 2 is applied last since it is younger in program order.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
      if (ld1_en_i && (ld1_addr_i == REG_W'(i))) cnt_d[i] = ld1_lat_i;
      if (ld2_en_i && (ld2_addr_i == REG_W'(i))) cnt_d[i] = ld2_lat_i;
    end
  end

  // Counter array register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd1_ra_o = cnt_q[rd1_ra_i];
  assign rd1_rb_o = cnt_q[rd1_rb_i];
  assign rd1_rc_o = cnt_q[rd1_rc_i];
  assign rd1_rt_o = cnt_q[rd1_rt_i];
  assign rd2_ra_o = cnt_q[rd2_ra_i];
  assign rd2_rb_o = cnt_q[rd2_rb_i];
  assign rd2_rc_o = cnt_q[rd2_rc_i];
  assign rd2_rt_o = cnt_q[rd2_rt_i];

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: checks RAW/WAW against the latency scoreboard
// plus intra-pair pipe, RAW and WAW conflicts, and issues slot 1, slot 2, both
// or neither each cycle. A slot 1 issue with a blocked slot 2 parks in SPLIT.
module dual_issue_scheduler
  import spu_sched_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  dual_issue_scheduler_if.slave bus
);

  slot_t            s1, s2;
  state_t           state_q, state_d;
  logic [LAT_W-1:0] c1_ra, c1_rb, c1_rc, c1_rt;
  logic [LAT_W-1:0] c2_ra, c2_rb, c2_rc, c2_rt;
  logic             rdy1, rdy2;
  logic             raw_intra, waw_intra, pipe_ok, pair2_ok;
  logic             issue1, issue2, in_ready;

  assign s1 = '{valid: bus.valid_1, ra: bus.ra_1, rb: bus.rb_1, rc: bus.rc_1,
                rt: bus.rt_1, use_src: bus.use_1, wr: bus.wr_1,
                pipe: pipe_t'(bus.pipe_1), lat: bus.lat_1};
  assign s2 = '{valid: bus.valid_2, ra: bus.ra_2, rb: bus.rb_2, rc: bus.rc_2,
                rt: bus.rt_2, use_src: bus.use_2, wr: bus.wr_2,
                pipe: pipe_t'(bus.pipe_2), lat: bus.lat_2};

  // A source is usable once its producer has at most one cycle left, so a
  // dependent issues exactly lat cycles after its producer.
  function automatic logic src_ok(input slot_t s, input logic [LAT_W-1:0] ca,
                                  input logic [LAT_W-1:0] cb, input logic [LAT_W-1:0] cc);
    return (!s.use_src[0] || (ca <= LAT_W'(1))) &&
           (!s.use_src[1] || (cb <= LAT_W'(1))) &&
           (!s.use_src[2] || (cc <= LAT_W'(1)));
  endfunction

  // A new writer must not complete before an older in-flight write to rt.
  function automatic logic waw_ok(input slot_t s, input logic [LAT_W-1:0] ct);
    return !s.wr || (ct <= s.lat);
  endfunction

  sched_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .ld1_en_i   (issue1 & s1.wr),
    .ld1_addr_i (s1.rt),
    .ld1_lat_i  (s1.lat),
    .ld2_en_i   (issue2 & s2.wr),
    .ld2_addr_i (s2.rt),
    .ld2_lat_i  (s2.lat),
    .rd1_ra_i   (s1.ra),
    .rd1_rb_i   (s1.rb),
    .rd1_rc_i   (s1.rc),
    .rd1_rt_i   (s1.rt),
    .rd1_ra_o   (c1_ra),
    .rd1_rb_o   (c1_rb),
    .rd1_rc_o   (c1_rc),
    .rd1_rt_o   (c1_rt),
    .rd2_ra_i   (s2.ra),
    .rd2_rb_i   (s2.rb),
    .rd2_rc_i   (s2.rc),
    .rd2_rt_i   (s2.rt),
    .rd2_ra_o   (c2_ra),
    .rd2_rb_o   (c2_rb),
    .rd2_rc_o   (c2_rc),
    .rd2_rt_o   (c2_rt)
  );

  // An empty slot is treated as ready and already issued.
  assign rdy1 = !s1.valid || (src_ok(s1, c1_ra, c1_rb, c1_rc) && waw_ok(s1, c1_rt));
  assign rdy2 = !s2.valid || (src_ok(s2, c2_ra, c2_rb, c2_rc) && waw_ok(s2, c2_rt));

  // Intra-pair conflicts only matter when slot 1 carries a real instruction.
  assign raw_intra = s1.valid && s1.wr &&
                     ((s2.use_src[0] && (s2.ra == s1.rt)) ||
                      (s2.use_src[1] && (s2.rb == s1.rt)) ||
                      (s2.use_src[2] && (s2.rc == s1.rt)));
  assign waw_intra = s1.valid && s1.wr && s2.wr && (s1.rt == s2.rt);
  assign pipe_ok   = !s1.valid || (s2.pipe != s1.pipe);
  assign pair2_ok  = rdy2 && (!s2.valid || (pipe_ok && !raw_intra && !waw_intra));

  // Issue decision and next state; flush and reset suppress all issue.
  always_comb begin
    state_d  = state_q;
    issue1   = 1'b0;
    issue2   = 1'b0;
    in_ready = 1'b0;
    if (!reset && !bus.flush_i && bus.pair_valid_i) begin
      case (state_q)
        PAIR: begin
          if (rdy1) begin
            issue1 = s1.valid;
            if (pair2_ok) begin
              issue2   = s2.valid;
              in_ready = 1'b1;
            end else begin
              state_d = SPLIT;
            end
          end
        end
        SPLIT: begin
          if (rdy2) begin
            issue2   = s2.valid;
            in_ready = 1'b1;
            state_d  = PAIR;
          end
        end
        default: state_d = PAIR;
      endcase
    end
    if (bus.flush_i) state_d = PAIR;
  end

  // State register; reset dominates flush.
  always_ff @(posedge clk) begin
    if (reset) state_q <= PAIR;
    else       state_q <= state_d;
  end

  assign bus.issue1_o   = issue1;
  assign bus.issue2_o   = issue2;
  assign bus.in_ready_o = in_ready;
  assign bus.split_o    = !reset && (state_q == SPLIT);

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with hand-computed expectations.
module tb_dual_issue_scheduler;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  dual_issue_scheduler_if bus ();

  dual_issue_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic clear_slots();
    bus.valid_1 = 1'b0; bus.ra_1 = '0; bus.rb_1 = '0; bus.rc_1 = '0; bus.rt_1 = '0;
    bus.use_1 = '0; bus.wr_1 = 1'b0; bus.pipe_1 = 1'b0; bus.lat_1 = '0;
    bus.valid_2 = 1'b0; bus.ra_2 = '0; bus.rb_2 = '0; bus.rc_2 = '0; bus.rt_2 = '0;
    bus.use_2 = '0; bus.wr_2 = 1'b0; bus.pipe_2 = 1'b0; bus.lat_2 = '0;
  endtask

  task automatic set_slot(input int idx, input logic [6:0] ra, input logic [6:0] rt,
                          input logic [2:0] use_bits, input logic wr, input logic pipe,
                          input logic [3:0] lat);
    if (idx == 1) begin
      bus.valid_1 = 1'b1; bus.ra_1 = ra; bus.rb_1 = '0; bus.rc_1 = '0; bus.rt_1 = rt;
      bus.use_1 = use_bits; bus.wr_1 = wr; bus.pipe_1 = pipe; bus.lat_1 = lat;
    end else begin
      bus.valid_2 = 1'b1; bus.ra_2 = ra; bus.rb_2 = '0; bus.rc_2 = '0; bus.rt_2 = rt;
      bus.use_2 = use_bits; bus.wr_2 = wr; bus.pipe_2 = pipe; bus.lat_2 = lat;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.flush_i = 1'b0;
    bus.pair_valid_i = 1'b1;
    clear_slots();
    // Independent pair held during reset: nothing may issue.
    set_slot(1, 7'd0, 7'd5, 3'b000, 1'b1, 1'b0, 4'd2);
    set_slot(2, 7'd0, 7'd9, 3'b000, 1'b1, 1'b1, 4'd4);
    #4;
    chk("rst_issue1", bus.issue1_o, 0);
    chk("rst_issue2", bus.issue2_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_split", bus.split_o, 0);
    tick();
    chk("rst_cnt5", dut.u_sb.cnt_q[5], 0);
    reset = 1'b0;

    // Independent pair, different pipes: both issue together.
    #3;
    chk("ind_issue1", bus.issue1_o, 1);
    chk("ind_issue2", bus.issue2_o, 1);
    chk("ind_in_ready", bus.in_ready_o, 1);
    tick();
    bus.pair_valid_i = 1'b0;
    #3;
    chk("ind_cnt5", dut.u_sb.cnt_q[5], 2);
    chk("ind_cnt9", dut.u_sb.cnt_q[9], 4);
    chk("idle_issue1", bus.issue1_o, 0);
    chk("idle_in_ready", bus.in_ready_o, 0);
    repeat (4) tick();

    // RAW against scoreboard: r3 lat 6, dependent stalls cycles 1-5.
    clear_slots();
    set_slot(1, 7'd0, 7'd3, 3'b000, 1'b1, 1'b0, 4'd6);
    bus.pair_valid_i = 1'b1;
    #3;
    chk("raw_prod_issue1", bus.issue1_o, 1);
    chk("raw_prod_issue2", bus.issue2_o, 0);
    chk("raw_prod_in_ready", bus.in_ready_o, 1);
    tick();
    set_slot(1, 7'd3, 7'd20, 3'b001, 1'b1, 1'b0, 4'd1);
    for (int c = 1; c <= 5; c++) begin
      #3;
      chk("raw_stall_issue1", bus.issue1_o, 0);
      chk("raw_stall_in_ready", bus.in_ready_o, 0);
      tick();
    end
    #3;
    chk("raw_go_issue1", bus.issue1_o, 1);
    chk("raw_go_in_ready", bus.in_ready_o, 1);
    tick();

    // Same-pipe pair: split over two cycles.
    clear_slots();
    set_slot(1, 7'd0, 7'd30, 3'b000, 1'b1, 1'b0, 4'd1);
    set_slot(2, 7'd0, 7'd31, 3'b000, 1'b1, 1'b0, 4'd1);
    #3;
    chk("pipe_issue1", bus.issue1_o, 1);
    chk("pipe_issue2", bus.issue2_o, 0);
    chk("pipe_in_ready", bus.in_ready_o, 0);
    tick();
    #3;
    chk("pipe_split", bus.split_o, 1);
    chk("pipe_sp_issue1", bus.issue1_o, 0);
    chk("pipe_sp_issue2", bus.issue2_o, 1);
    chk("pipe_sp_in_ready", bus.in_ready_o, 1);
    tick();
    #3;
    chk("pipe_back_pair", bus.split_o, 0);

    // Intra-pair RAW on r10 with lat 1.
    clear_slots();
    set_slot(1, 7'd0, 7'd10, 3'b000, 1'b1, 1'b0, 4'd1);
    set_slot(2, 7'd10, 7'd11, 3'b001, 1'b1, 1'b1, 4'd1);
    #3;
    chk("iraw_issue1", bus.issue1_o, 1);
    chk("iraw_issue2", bus.issue2_o, 0);
    tick();
    #3;
    chk("iraw_split", bus.split_o, 1);
    chk("iraw_sp_issue2", bus.issue2_o, 1);
    chk("iraw_sp_in_ready", bus.in_ready_o, 1);
    tick();

    // WAW: r7 at 8, new writer with lat 2 waits until cnt <= 2.
    clear_slots();
    set_slot(1, 7'd0, 7'd7, 3'b000, 1'b1, 1'b0, 4'd8);
    #3;
    chk("waw_prod_issue1", bus.issue1_o, 1);
    tick();
    set_slot(1, 7'd0, 7'd7, 3'b000, 1'b1, 1'b0, 4'd2);
    for (int c = 0; c < 6; c++) begin
      #3;
      chk("waw_stall_issue1", bus.issue1_o, 0);
      tick();
    end
    #3;
    chk("waw_go_issue1", bus.issue1_o, 1);
    chk("waw_go_in_ready", bus.in_ready_o, 1);
    tick();
    bus.pair_valid_i = 1'b0;
    #3;
    chk("waw_cnt7", dut.u_sb.cnt_q[7], 2);

    // Flush while in SPLIT, then reset during a stall.
    clear_slots();
    bus.pair_valid_i = 1'b1;
    set_slot(1, 7'd0, 7'd40, 3'b000, 1'b1, 1'b0, 4'd5);
    set_slot(2, 7'd40, 7'd41, 3'b001, 1'b1, 1'b1, 4'd3);
    #3;
    chk("fl_issue1", bus.issue1_o, 1);
    chk("fl_issue2", bus.issue2_o, 0);
    tick();
    bus.flush_i = 1'b1;
    #3;
    chk("fl_split", bus.split_o, 1);
    chk("fl_issue2_flushed", bus.issue2_o, 0);
    chk("fl_in_ready", bus.in_ready_o, 0);
    chk("fl_issue1_flushed", bus.issue1_o, 0);
    tick();
    bus.flush_i = 1'b0;
    clear_slots();
    set_slot(1, 7'd40, 7'd42, 3'b001, 1'b1, 1'b0, 4'd1);
    #3;
    chk("fl_state_pair", bus.split_o, 0);
    chk("fl_cnt40_kept", dut.u_sb.cnt_q[40], 4);
    chk("fl_cnt41_none", dut.u_sb.cnt_q[41], 0);
    chk("stall_issue1", bus.issue1_o, 0);
    tick();
    reset = 1'b1;
    #3;
    chk("mid_rst_issue1", bus.issue1_o, 0);
    chk("mid_rst_in_ready", bus.in_ready_o, 0);
    chk("mid_rst_split", bus.split_o, 0);
    tick();
    #3;
    chk("mid_rst_cnt40", dut.u_sb.cnt_q[40], 0);
    chk("mid_rst_issue1_b", bus.issue1_o, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_issue1", bus.issue1_o, 1);
    chk("post_rst_in_ready", bus.in_ready_o, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
